control_sumatoria: RTL and testbench



---
 rtl/control_sumatoria.sv | 104 ++++++++++
 tb/tb_control_sumatoria.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sumatoria.sv
// Sequencing controller for an external Sumatoria popcount block: builds the
// oversampled window, takes a majority decision with tie hysteresis, and hands it off via valid/ready.
module control_sumatoria #(
  parameter int SAMPLES = 2,
  parameter int OSF     = 8,
  localparam int N      = SAMPLES * OSF,
  localparam int SW     = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          din,
  input  logic          din_valid,
  output logic [N-1:0]  win,
  input  logic [SW-1:0] sum,
  output logic          bit_out,
  output logic          bit_valid,
  input  logic          bit_ready,
  output logic          busy,
  output logic          overrun
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] EVAL = 2'd2;
  localparam logic [1:0] OUT  = 2'd3;

  localparam int CW = $clog2(N + 1);
  localparam logic [SW-1:0] HALF = SW'(N / 2);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          prev;
  logic          complete;
  logic          handshake;
  logic          decision;

  assign complete  = din_valid && (cnt == LAST);
  assign handshake = bit_valid && bit_ready;
  assign busy      = (state != IDLE);

  // A tie keeps the previous decision so a balanced window cannot flip the output.
  always_comb begin
    decision = prev;
    if (sum > HALF)
      decision = 1'b1;
    else if (sum < HALF)
      decision = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      win       <= '0;
      cnt       <= '0;
      prev      <= 1'b0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (state == IDLE) begin
      cnt <= '0;
      if (start && !stop) begin
        state   <= FILL;
        win     <= '0;
        overrun <= 1'b0;
        prev    <= 1'b0;
      end
    end else if (stop) begin
      state     <= IDLE;
      bit_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      // Samples keep flowing in every active state, so EVAL/OUT cycles feed the next window.
      if (din_valid) begin
        win <= {win[N-2:0], din};
        cnt <= complete ? '0 : cnt + 1'b1;
      end
      case (state)
        FILL: begin
          if (complete)
            state <= EVAL;
        end
        EVAL: begin
          bit_out   <= decision;
          prev      <= decision;
          bit_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (handshake) begin
            bit_valid <= 1'b0;
            state     <= complete ? EVAL : FILL;
          end else if (complete) begin
            overrun <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sumatoria.sv
// Scoreboard bench for control_sumatoria: directed windows push expected decisions,
// and a negedge monitor pops and compares on each valid/ready transfer.
module tb_control_sumatoria;

  localparam int SAMPLES = 2;
  localparam int OSF     = 8;
  localparam int N       = SAMPLES * OSF;
  localparam int SW      = $clog2(N) + 1;

  logic          clk;
  logic          rst;
  logic          start;
  logic          stop;
  logic          din;
  logic          din_valid;
  logic [N-1:0]  win;
  logic [SW-1:0] sum;
  logic          bit_out;
  logic          bit_valid;
  logic          bit_ready;
  logic          busy;
  logic          overrun;

  int n_compared   = 0;
  int n_mismatched = 0;
  logic exp_q[$];

  control_sumatoria #(.SAMPLES(SAMPLES), .OSF(OSF)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .din       (din),
    .din_valid (din_valid),
    .win       (win),
    .sum       (sum),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .busy      (busy),
    .overrun   (overrun)
  );

  // Zero-latency Sumatoria stand-in.
  assign sum = SW'($countones(win));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Transfers happen at the next rising edge; inputs are settled by the falling edge.
  always @(negedge clk) begin
    if (!rst && !stop && bit_valid === 1'b1 && bit_ready === 1'b1) begin
      n_compared++;
      if (exp_q.size() == 0) begin
        n_mismatched++;
        $display("[TB] FAIL transfer: actual bit_out=%0b required=no transfer pending", bit_out);
      end else begin
        logic exp_bit;
        exp_bit = exp_q.pop_front();
        if (bit_out !== exp_bit) begin
          n_mismatched++;
          $display("[TB] FAIL transfer: actual bit_out=%0b required=%0b", bit_out, exp_bit);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Shift word[first] down to word[last] on consecutive cycles, then idle din_valid.
  task automatic applyStimulus(input logic [15:0] word, input int first, input int last);
    for (int i = first; i >= last; i--) begin
      din       = word[i];
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
  endtask

  task automatic run_window(input string name, input logic [15:0] word, input logic expected);
    exp_q.push_back(expected);
    applyStimulus(word, 15, 0);
    checkOutput({name, "_win"}, win, word);
    checkOutput({name, "_eval_valid"}, 16'(bit_valid), 16'h0);
    tick();
    checkOutput({name, "_valid"}, 16'(bit_valid), 16'h1);
    checkOutput({name, "_bit"}, 16'(bit_out), 16'(expected));
    tick();
    checkOutput({name, "_drop"}, 16'(bit_valid), 16'h0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; stop = 1'b0;
    din = 1'b1; din_valid = 1'b1; bit_ready = 1'b1;

    // Reset dominates start and din_valid
    tick();
    tick();
    checkOutput("rst_bit_out", 16'(bit_out), 16'h0);
    checkOutput("rst_bit_valid", 16'(bit_valid), 16'h0);
    checkOutput("rst_busy", 16'(busy), 16'h0);
    checkOutput("rst_overrun", 16'(overrun), 16'h0);
    checkOutput("rst_win", win, 16'h0);
    rst = 1'b0; start = 1'b0; din_valid = 1'b0;
    tick();
    checkOutput("idle_busy", 16'(busy), 16'h0);

    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("start_busy", 16'(busy), 16'h1);

    // Full window and thresholds with hysteresis
    run_window("full", 16'hFFFF, 1'b1);
    run_window("five", 16'h001F, 1'b0);
    run_window("tie_after0", 16'h00FF, 1'b0);
    run_window("twelve", 16'h0FFF, 1'b1);
    run_window("tie_after1", 16'h00FF, 1'b1);

    // Backpressure: window 1 = ones, window 2 = zeros dropped as overrun
    bit_ready = 1'b0;
    exp_q.push_back(1'b1);
    for (int i = 0; i < 40; i++) begin
      din       = (i < 16);
      din_valid = 1'b1;
      tick();
      if (i == 30) checkOutput("bp_no_overrun", 16'(overrun), 16'h0);
      if (i == 31) checkOutput("bp_overrun", 16'(overrun), 16'h1);
    end
    din_valid = 1'b0;
    checkOutput("bp_held_valid", 16'(bit_valid), 16'h1);
    checkOutput("bp_held_bit", 16'(bit_out), 16'h1);
    bit_ready = 1'b1;
    tick();
    checkOutput("bp_after_xfer", 16'(bit_valid), 16'h0);
    tick();
    checkOutput("bp_single_xfer", 16'(bit_valid), 16'h0);
    // Eight zeros already sit in the window; eight ones make a tie after a 1
    exp_q.push_back(1'b1);
    applyStimulus(16'h00FF, 7, 0);
    checkOutput("bp_resume_win", win, 16'h00FF);
    tick();
    checkOutput("bp_resume_bit", 16'(bit_out), 16'h1);
    tick();
    checkOutput("bp_overrun_sticky", 16'(overrun), 16'h1);

    // Abort paths
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checkOutput("stop_busy", 16'(busy), 16'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("restart_overrun", 16'(overrun), 16'h0);
    checkOutput("restart_win", win, 16'h0);
    applyStimulus(16'h007F, 6, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checkOutput("abort_busy", 16'(busy), 16'h0);
    stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
    checkOutput("stop_start_idle", 16'(busy), 16'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_q.push_back(1'b1);
    applyStimulus(16'h0FFF, 15, 1);
    tick();
    checkOutput("fresh_15_valid", 16'(bit_valid), 16'h0);
    tick();
    checkOutput("fresh_15_valid2", 16'(bit_valid), 16'h0);
    applyStimulus(16'h0FFF, 0, 0);
    checkOutput("fresh_win", win, 16'h0FFF);
    tick();
    checkOutput("fresh_valid", 16'(bit_valid), 16'h1);
    checkOutput("fresh_bit", 16'(bit_out), 16'h1);
    tick();

    // Ready arrives on the edge completing the next window
    bit_ready = 1'b0;
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 32; i++) begin
      din       = (i < 16);
      din_valid = 1'b1;
      if (i == 31) bit_ready = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    checkOutput("same_edge_overrun", 16'(overrun), 16'h0);
    checkOutput("same_edge_eval", 16'(bit_valid), 16'h0);
    tick();
    checkOutput("same_edge_valid", 16'(bit_valid), 16'h1);
    checkOutput("same_edge_bit", 16'(bit_out), 16'h0);
    tick();

    // din_valid every other cycle; the EVAL-cycle sample starts the next window
    exp_q.push_back(1'b0);
    for (int j = 0; j < 16; j++) begin
      din       = 16'h001F >> (15 - j);
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      if (j < 15) tick();
    end
    checkOutput("toggle_win", win, 16'h001F);
    checkOutput("toggle_eval", 16'(bit_valid), 16'h0);
    exp_q.push_back(1'b1);
    din       = 1'b0;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    checkOutput("toggle_valid", 16'(bit_valid), 16'h1);
    checkOutput("toggle_bit", 16'(bit_out), 16'h0);
    tick();
    for (int j = 1; j < 16; j++) begin
      din       = 16'h0FFF >> (15 - j);
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      tick();
    end
    checkOutput("toggle2_win", win, 16'h0FFF);
    checkOutput("toggle2_valid", 16'(bit_valid), 16'h1);
    checkOutput("toggle2_bit", 16'(bit_out), 16'h1);
    tick();
    tick();

    checkOutput("queue_empty", 16'(exp_q.size()), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
